// File: rtl/fp16_pkg.sv
// ---------------------------------------------------------------------------
// fp16_pkg
// Shared definitions for the FP16 multiplier scheduler slice: operand width,
// FP16 field layout (sign / exponent / mantissa) and the scheduler state type.
// ---------------------------------------------------------------------------
package fp16_pkg;

   localparam int FP16_W        = 16;
   localparam int FP16_MAN_W    = 10;
   localparam int FP16_EXP_W    = 5;
   localparam int FP16_MAN_LSB  = 0;
   localparam int FP16_EXP_LSB  = 10;
   localparam int FP16_SIGN_BIT = 15;

   typedef logic [FP16_W-1:0] fp16_t;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } sched_state_t;

endpackage

// File: rtl/fp16_mul_sched_if.sv
// ---------------------------------------------------------------------------
// fp16_mul_sched_if
// Requester-side bus of the scheduler: per-requester operand handshake and
// the shared result strobe.
//   req_valid[NREQ]   requester -> scheduler, operand pair valid
//   req_ready[NREQ]   scheduler -> requester, one-hot accept
//   req_a/req_b       packed FP16 operands, requester i at [16i+15:16i]
//   rsp_valid/id/data one-cycle result strobe with originating requester
// master: requester side, slave: scheduler side.
// ---------------------------------------------------------------------------
interface fp16_mul_sched_if #(
   parameter int NREQ = 4
) ();
   import fp16_pkg::*;

   localparam int ID_W = $clog2(NREQ);

   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_ready;
   logic [FP16_W*NREQ-1:0] req_a;
   logic [FP16_W*NREQ-1:0] req_b;
   logic                   rsp_valid;
   logic [ID_W-1:0]        rsp_id;
   fp16_t                  rsp_data;

   modport master (
      output req_valid, req_a, req_b,
      input  req_ready, rsp_valid, rsp_id, rsp_data
   );

   modport slave (
      input  req_valid, req_a, req_b,
      output req_ready, rsp_valid, rsp_id, rsp_data
   );

endinterface

// File: rtl/fp16_tag_fifo.sv
// ---------------------------------------------------------------------------
// fp16_tag_fifo
// In-order tag FIFO holding the requester ID of every operation in flight.
// Read data is the current head (first-word fall-through).
//   clk, rst_n   clock, asynchronous active-low reset
//   push/wr_data enqueue a tag (ignored when full)
//   pop          dequeue the head (ignored when empty)
//   flush        drop all entries; wins over push/pop
//   rd_data      head tag
//   empty/full/count  occupancy
// ---------------------------------------------------------------------------
module fp16_tag_fifo #(
   parameter  int DEPTH = 4,
   parameter  int W     = 2,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [W-1:0]  wr_data,
   output logic [W-1:0]  rd_data,
   output logic          empty,
   output logic          full,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CW'(DEPTH));
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign rd_data = mem[rd_ptr_reg];
   assign count   = count_reg;

   // Storage carries no reset: an entry is only read after it was written.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/fp16_mul_sched.sv
// ---------------------------------------------------------------------------
// fp16_mul_sched
// Round-robin scheduler sharing one FP16 multiplier among NREQ requesters.
// At most one operation is issued per cycle; returning products are matched
// to requesters through an in-order tag FIFO. If the oldest operation waits
// TIMEOUT cycles, the multiplier is reset for two cycles and all in-flight
// work is dropped.
//   clk, rst_n          clock, asynchronous active-low reset
//   bus (slave)         requester handshakes and result strobe
//   mul_data1/2         operands to the multiplier (held when idle)
//   mul_input_valid     one-cycle pulse per issued operation
//   mul_rst             active-high multiplier reset
//   mul_datanew         multiplier result
//   mul_output_update   multiplier result strobe, in issue order
//   busy                operations in flight
//   err_timeout         sticky, multiplier timed out
//   err_spurious        sticky, result strobe with nothing in flight
// ---------------------------------------------------------------------------
module fp16_mul_sched
   import fp16_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   fp16_mul_sched_if.slave bus,
   output fp16_t           mul_data1,
   output fp16_t           mul_data2,
   output logic            mul_input_valid,
   output logic            mul_rst,
   input  fp16_t           mul_datanew,
   input  logic            mul_output_update,
   output logic            busy,
   output logic            err_timeout,
   output logic            err_spurious
);

   localparam int ID_W  = $clog2(NREQ);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int TMR_W = $clog2(TIMEOUT + 1);

   sched_state_t    state_reg, state_next;
   logic            flush_cnt_reg, flush_cnt_next;
   logic [ID_W-1:0] ptr_reg;
   logic [TMR_W-1:0] timer_reg;

   fp16_t           data1_reg, data2_reg, rsp_data_reg;
   logic            input_valid_reg, mul_rst_reg, rsp_valid_reg;
   logic [ID_W-1:0] rsp_id_reg;
   logic            err_timeout_reg, err_spurious_reg;

   logic [ID_W-1:0] rr_idx [NREQ];
   fp16_t           req_a_arr [NREQ];
   fp16_t           req_b_arr [NREQ];
   logic [NREQ-1:0] grant;
   logic [ID_W-1:0] grant_id;
   logic            grant_found;

   logic            fifo_empty, fifo_full;
   logic [ID_W-1:0] fifo_rd_id;
   logic [CNT_W-1:0] fifo_count;
   logic            arb_en, issue, ret, spur, timeout_hit;

   // Search order starting at the pointer, and unpacked operand views.
   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_req
         assign rr_idx[gi]    = ID_W'((int'(ptr_reg) + gi) % NREQ);
         assign req_a_arr[gi] = bus.req_a[FP16_W*gi +: FP16_W];
         assign req_b_arr[gi] = bus.req_b[FP16_W*gi +: FP16_W];
      end
   endgenerate

   // A return and a timeout cannot coincide: a return restarts the timer.
   assign ret         = mul_output_update && (state_reg == RUN) && !fifo_empty;
   assign spur        = mul_output_update && (state_reg == RUN) && fifo_empty;
   assign timeout_hit = (state_reg == RUN) && !fifo_empty && !ret &&
                        (timer_reg == TMR_W'(TIMEOUT - 1));
   // No issue in the timeout cycle, so nothing is pushed into a flushing FIFO.
   assign arb_en      = (state_reg == RUN) && !fifo_full && !timeout_hit;
   assign issue       = grant_found;

   always_comb begin
      grant       = '0;
      grant_id    = '0;
      grant_found = 1'b0;
      if (arb_en) begin
         for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && bus.req_valid[rr_idx[k]]) begin
               grant_found       = 1'b1;
               grant_id          = rr_idx[k];
               grant[rr_idx[k]]  = 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_next     = state_reg;
      flush_cnt_next = flush_cnt_reg;
      case (state_reg)
         RUN: begin
            if (timeout_hit) begin
               state_next     = FLUSH;
               flush_cnt_next = 1'b0;
            end
         end
         FLUSH: begin
            flush_cnt_next = flush_cnt_reg + 1'b1;
            if (flush_cnt_reg) state_next = RUN;
         end
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= RUN;
         flush_cnt_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         flush_cnt_reg <= flush_cnt_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_reg          <= '0;
         timer_reg        <= '0;
         data1_reg        <= '0;
         data2_reg        <= '0;
         input_valid_reg  <= 1'b0;
         mul_rst_reg      <= 1'b1;
         rsp_valid_reg    <= 1'b0;
         rsp_id_reg       <= '0;
         rsp_data_reg     <= '0;
         err_timeout_reg  <= 1'b0;
         err_spurious_reg <= 1'b0;
      end else begin
         if (issue) begin
            ptr_reg   <= (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;
            data1_reg <= req_a_arr[grant_id];
            data2_reg <= req_b_arr[grant_id];
         end
         // Timer only runs while the oldest op is waiting for its result.
         if (ret || fifo_empty || timeout_hit) timer_reg <= '0;
         else                                  timer_reg <= timer_reg + 1'b1;
         input_valid_reg <= issue;
         mul_rst_reg     <= (state_next == FLUSH);
         rsp_valid_reg   <= ret;
         if (ret) begin
            rsp_id_reg   <= fifo_rd_id;
            rsp_data_reg <= mul_datanew;
         end
         if (timeout_hit) err_timeout_reg  <= 1'b1;
         if (spur)        err_spurious_reg <= 1'b1;
      end
   end

   fp16_tag_fifo #(
      .DEPTH (DEPTH),
      .W     (ID_W)
   ) u_tag_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (issue),
      .pop     (ret),
      .flush   (timeout_hit),
      .wr_data (grant_id),
      .rd_data (fifo_rd_id),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .count   (fifo_count)
   );

   assign bus.req_ready   = grant;
   assign bus.rsp_valid   = rsp_valid_reg;
   assign bus.rsp_id      = rsp_id_reg;
   assign bus.rsp_data    = rsp_data_reg;
   assign mul_data1       = data1_reg;
   assign mul_data2       = data2_reg;
   assign mul_input_valid = input_valid_reg;
   assign mul_rst         = mul_rst_reg;
   assign busy            = (fifo_count != '0);
   assign err_timeout     = err_timeout_reg;
   assign err_spurious    = err_spurious_reg;

endmodule

// File: tb/tb_fp16_mul_sched.sv
// ---------------------------------------------------------------------------
// tb_fp16_mul_sched
// Cycle-stepped bench: a behavioural multiplier stub with programmable
// latency (or hang), a reference FP16 multiply, and a transaction-level
// model of the scheduler (in-flight op queue, round-robin pointer, wait
// timer, flush window) that predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_fp16_mul_sched;
   import fp16_pkg::*;

   localparam int NREQ    = 4;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 64;

   logic  clk   = 1'b0;
   logic  rst_n = 1'b1;
   fp16_t mul_data1, mul_data2, mul_datanew;
   logic  mul_input_valid, mul_rst, mul_output_update;
   logic  busy, err_timeout, err_spurious;

   always #5 clk = ~clk;

   fp16_mul_sched_if #(.NREQ(NREQ)) bus ();

   fp16_mul_sched #(
      .NREQ    (NREQ),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .bus               (bus),
      .mul_data1         (mul_data1),
      .mul_data2         (mul_data2),
      .mul_input_valid   (mul_input_valid),
      .mul_rst           (mul_rst),
      .mul_datanew       (mul_datanew),
      .mul_output_update (mul_output_update),
      .busy              (busy),
      .err_timeout       (err_timeout),
      .err_spurious      (err_spurious)
   );

   typedef struct { int id; fp16_t a; fp16_t b; } op_t;
   typedef struct { int due; fp16_t res; } stub_t;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // stimulus
   logic [NREQ-1:0] valid;
   fp16_t op_a [NREQ];
   fp16_t op_b [NREQ];

   // multiplier stub
   stub_t stub_q [$];
   int    stub_lat;
   bit    stub_hang;
   bit    force_strobe;

   // scheduler model
   op_t   m_ops [$];
   int    m_ptr, m_timer, m_flush_left;
   bit    m_rst_hold, m_err_to, m_err_sp;
   bit    m_iv_pend, m_rsp_pend;
   fp16_t m_iv_a, m_iv_b, m_rsp_data;
   int    m_rsp_id;

   // observations
   int    n_hs, n_rsp, last_hs_cyc, last_rsp_cyc, last_iv_cyc, to_cyc, mulrst_cycles;
   int    last_rsp_id, rsp2_data;
   fp16_t last_rsp_data;
   int    hs_per [NREQ];

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference FP16 multiply for normal operands with normal results,
   // round to nearest, ties to even.
   function automatic fp16_t fp16_mul_ref(input fp16_t a, input fp16_t b);
      int          e, sh;
      int unsigned ma, mb, p, m, rem, half;
      logic        s;
      s  = a[FP16_SIGN_BIT] ^ b[FP16_SIGN_BIT];
      e  = int'(a[FP16_EXP_LSB +: FP16_EXP_W]) + int'(b[FP16_EXP_LSB +: FP16_EXP_W])
           - ((1 << (FP16_EXP_W - 1)) - 1);
      ma = (1 << FP16_MAN_W) | int'(a[FP16_MAN_LSB +: FP16_MAN_W]);
      mb = (1 << FP16_MAN_W) | int'(b[FP16_MAN_LSB +: FP16_MAN_W]);
      p  = ma * mb;
      sh = FP16_MAN_W;
      if (p >= (1 << (2 * FP16_MAN_W + 1))) begin
         sh++;
         e++;
      end
      m    = p >> sh;
      rem  = p & ((1 << sh) - 1);
      half = 1 << (sh - 1);
      if (rem > half || (rem == half && (m & 1) == 1)) m++;
      if (m == (2 << FP16_MAN_W)) begin
         m = m >> 1;
         e++;
      end
      return {s, 5'(e), 10'(m)};
   endfunction

   function automatic fp16_t rand_fp16();
      return {1'($urandom_range(0, 1)), 5'($urandom_range(10, 20)), 10'($urandom)};
   endfunction

   // One clock cycle: drive inputs, predict and compare, advance the model.
   task automatic step();
      int    exp_grant, cnt0;
      bit    strobe, flushing, ret, spur, to_hit, arb_en;
      fp16_t sdata;
      op_t   op;
      stub_t s;

      bus.req_valid = valid;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_a[FP16_W*i +: FP16_W] = op_a[i];
         bus.req_b[FP16_W*i +: FP16_W] = op_b[i];
      end
      strobe = 1'b0;
      sdata  = fp16_t'($urandom);
      if (!mul_rst && !stub_hang && stub_q.size() > 0 && stub_q[0].due <= cyc) begin
         strobe = 1'b1;
         sdata  = stub_q[0].res;
         void'(stub_q.pop_front());
      end else if (force_strobe) begin
         strobe = 1'b1;
      end
      mul_output_update = strobe;
      mul_datanew       = sdata;
      #1;

      cnt0     = m_ops.size();
      flushing = (m_flush_left > 0);
      ret      = strobe && !flushing && cnt0 > 0;
      spur     = strobe && !flushing && cnt0 == 0;
      to_hit   = !flushing && cnt0 > 0 && !ret && m_timer == TIMEOUT - 1;
      arb_en   = !flushing && cnt0 < DEPTH && !to_hit;
      exp_grant = -1;
      if (arb_en) begin
         for (int k = 0; k < NREQ; k++) begin
            int idx = (m_ptr + k) % NREQ;
            if (exp_grant < 0 && valid[idx]) exp_grant = idx;
         end
      end

      check_eq("req_ready", bus.req_ready, (exp_grant < 0) ? 0 : (1 << exp_grant));
      check_eq("mul_input_valid", mul_input_valid, m_iv_pend);
      if (m_iv_pend) begin
         check_eq("mul_data1", mul_data1, m_iv_a);
         check_eq("mul_data2", mul_data2, m_iv_b);
      end
      check_eq("rsp_valid", bus.rsp_valid, m_rsp_pend);
      if (m_rsp_pend) begin
         check_eq("rsp_id", bus.rsp_id, m_rsp_id);
         check_eq("rsp_data", bus.rsp_data, m_rsp_data);
      end
      check_eq("mul_rst", mul_rst, m_rst_hold || flushing);
      check_eq("busy", busy, cnt0 > 0);
      check_eq("err_timeout", err_timeout, m_err_to);
      check_eq("err_spurious", err_spurious, m_err_sp);

      // observations
      for (int i = 0; i < NREQ; i++) begin
         if (bus.req_ready[i] && valid[i]) hs_per[i]++;
      end
      if (mul_input_valid) last_iv_cyc = cyc;
      if (mul_rst) mulrst_cycles++;
      if (err_timeout && to_cyc < 0) to_cyc = cyc;
      if (bus.rsp_valid) begin
         n_rsp++;
         last_rsp_cyc  = cyc;
         last_rsp_id   = bus.rsp_id;
         last_rsp_data = bus.rsp_data;
         if (bus.rsp_id == 2) rsp2_data = bus.rsp_data;
         $display("rsp cycle=%0d id=%0d data=%h", cyc, bus.rsp_id, bus.rsp_data);
      end

      // model update
      m_rsp_pend = ret;
      if (ret) begin
         op         = m_ops.pop_front();
         m_rsp_id   = op.id;
         m_rsp_data = fp16_mul_ref(op.a, op.b);
      end
      m_iv_pend = (exp_grant >= 0);
      if (exp_grant >= 0) begin
         op.id  = exp_grant;
         op.a   = op_a[exp_grant];
         op.b   = op_b[exp_grant];
         m_iv_a = op.a;
         m_iv_b = op.b;
         m_ops.push_back(op);
         m_ptr  = (exp_grant + 1) % NREQ;
         n_hs++;
         last_hs_cyc = cyc;
      end
      if (ret || cnt0 == 0 || to_hit) m_timer = 0;
      else                            m_timer++;
      if (flushing) begin
         m_flush_left--;
      end else if (to_hit) begin
         m_flush_left = 2;
         m_ops.delete();
         m_err_to = 1'b1;
      end
      if (spur) m_err_sp = 1'b1;
      m_rst_hold = 1'b0;

      // stub capture
      if (mul_rst) begin
         stub_q.delete();
      end else if (mul_input_valid && !stub_hang) begin
         s.due = cyc + stub_lat;
         s.res = fp16_mul_ref(mul_data1, mul_data2);
         stub_q.push_back(s);
      end

      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic apply_reset();
      #2;
      rst_n             = 1'b0;
      valid             = '0;
      bus.req_valid     = '0;
      mul_output_update = 1'b0;
      #1;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_mul_rst", mul_rst, 1);
      check_eq("rst_rsp_valid", bus.rsp_valid, 0);
      check_eq("rst_input_valid", mul_input_valid, 0);
      check_eq("rst_req_ready", bus.req_ready, 0);
      check_eq("rst_err_timeout", err_timeout, 0);
      check_eq("rst_err_spurious", err_spurious, 0);
      m_ops.delete();
      stub_q.delete();
      m_ptr = 0; m_timer = 0; m_flush_left = 0;
      m_rst_hold = 1'b1; m_err_to = 1'b0; m_err_sp = 1'b0;
      m_iv_pend = 1'b0; m_rsp_pend = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int h0, rsp_before;

      valid = '0;
      for (int i = 0; i < NREQ; i++) begin
         op_a[i]   = rand_fp16();
         op_b[i]   = rand_fp16();
         hs_per[i] = 0;
      end
      stub_lat = 3; stub_hang = 1'b0; force_strobe = 1'b0;
      n_hs = 0; n_rsp = 0; last_hs_cyc = 0; last_rsp_cyc = 0; last_iv_cyc = 0;
      to_cyc = -1; mulrst_cycles = 0; last_rsp_id = -1; rsp2_data = 0;
      last_rsp_data = '0; mul_output_update = 1'b0; mul_datanew = '0;
      bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0;

      apply_reset();

      // single op from requester 0
      op_a[0] = 16'h5bf0; op_b[0] = 16'h47af; valid = 4'b0001;
      step();
      h0 = last_hs_cyc;
      valid = '0;
      repeat (8) step();
      check_eq("single_latency", last_rsp_cyc - h0, stub_lat + 2);
      check_eq("single_rsp_cnt", n_rsp, 1);
      check_eq("single_id", last_rsp_id, 0);
      check_eq("single_data", last_rsp_data, 16'h67a0);

      // contention: all requesters valid, constant operands
      stub_lat = 1;
      op_a[2] = 16'h4440; op_b[2] = 16'h4660;
      for (int i = 0; i < NREQ; i++) hs_per[i] = 0;
      valid = 4'b1111;
      repeat (16) step();
      valid = '0;
      repeat (6) step();
      for (int i = 0; i < NREQ; i++) check_eq("contention_share", hs_per[i], 4);
      check_eq("contention_req2_data", rsp2_data, 16'h4ec6);

      // full: long multiplier latency with every requester valid
      stub_lat = 10;
      h0 = n_hs;
      valid = 4'b1111;
      repeat (12) step();
      check_eq("full_issue_cnt", n_hs - h0, DEPTH);
      repeat (30) step();
      valid = '0;
      repeat (16) step();

      // randomized traffic at several latencies
      for (int ph = 0; ph < 4; ph++) begin
         stub_lat = $urandom_range(1, 8);
         for (int c = 0; c < 75; c++) begin
            valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
               op_a[i] = rand_fp16();
               op_b[i] = rand_fp16();
            end
            step();
         end
         valid = '0;
         repeat (14) step();
      end

      // timeout: multiplier never answers
      stub_hang = 1'b1;
      stub_lat = 4;
      to_cyc = -1; mulrst_cycles = 0;
      rsp_before = n_rsp;
      valid = 4'b0010;
      step();
      valid = '0;
      for (int c = 0; c < 80; c++) begin
         force_strobe = (m_flush_left == 2);  // strobe inside FLUSH is ignored
         step();
         force_strobe = 1'b0;
      end
      check_eq("timeout_delay", to_cyc - last_iv_cyc, TIMEOUT);
      check_eq("timeout_mul_rst_cycles", mulrst_cycles, 2);
      check_eq("timeout_no_rsp", n_rsp, rsp_before);
      stub_hang = 1'b0;
      valid = 4'b1000;
      step();
      valid = '0;
      repeat (10) step();
      check_eq("after_timeout_rsp", n_rsp, rsp_before + 1);

      // spurious strobe while idle
      rsp_before = n_rsp;
      force_strobe = 1'b1;
      step();
      force_strobe = 1'b0;
      repeat (3) step();
      check_eq("spurious_flag", err_spurious, 1);
      check_eq("spurious_no_rsp", n_rsp, rsp_before);

      // asynchronous reset with three ops in flight
      stub_lat = 10;
      valid = 4'b1111;
      repeat (3) step();
      valid = '0;
      repeat (2) step();
      apply_reset();
      rsp_before = n_rsp;
      repeat (20) step();
      check_eq("reset_no_rsp", n_rsp, rsp_before);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
